clk_div_multi: RTL and testbench

CLK_DIV_MULTI -- requirements
Module: clk_div_multi

---
 rtl/clk_div_pkg.sv | 14 +
 rtl/clk_div_ch.sv | 117 +++++++++++
 rtl/clk_div_multi.sv | 42 ++++
 tb/tb_clk_div_multi.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared definitions for the multi-channel clock divider.
//   ch_state_e : per-channel FSM state (IDLE, LOW, HIGH)
//   MIN_RATIO  : smallest division ratio that starts a channel
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } ch_state_e;

  localparam int unsigned MIN_RATIO = 2;

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: low for floor(R/2) cycles, then high for R - floor(R/2)
// cycles. The ratio is latched only at start, at period boundaries and on sync.
//   clk     : reference clock (rising edge)
//   rst_n   : asynchronous active-low reset
//   en      : run enable, sampled at start / period boundary / sync
//   ratio   : requested division ratio
//   sync    : phase-align pulse (restarts the period if runnable)
//   div_clk : divided clock, straight from a flop
//   tick    : one-cycle strobe in the first cycle of each period
//   active  : channel is in LOW or HIGH
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int unsigned RATIO_WD = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [RATIO_WD-1:0] ratio,
  input  logic                sync,
  output logic                div_clk,
  output logic                tick,
  output logic                active
);

  ch_state_e           state, state_nxt;
  logic [RATIO_WD-1:0] cnt, cnt_nxt;
  logic [RATIO_WD-1:0] rl, rl_nxt;
  logic                tick_nxt;
  logic                runnable;
  logic [RATIO_WD-1:0] half_lo, half_hi;
  logic [RATIO_WD-1:0] lo_last, hi_last;

  assign runnable = en && (ratio >= RATIO_WD'(MIN_RATIO));
  assign half_lo  = rl >> 1;
  assign half_hi  = rl - half_lo;
  // Terminal counts; rl >= 2 whenever these are consulted, so no underflow.
  assign lo_last  = half_lo - RATIO_WD'(1);
  assign hi_last  = half_hi - RATIO_WD'(1);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rl_nxt    = rl;
    tick_nxt  = 1'b0;

    if (sync) begin
      // Sync overrides whatever the phase is; at a boundary this is identical
      // to the normal reload.
      if (runnable) begin
        state_nxt = LOW;
        cnt_nxt   = '0;
        rl_nxt    = ratio;
        tick_nxt  = 1'b1;
      end else begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          cnt_nxt = '0;
          if (runnable) begin
            state_nxt = LOW;
            rl_nxt    = ratio;
            tick_nxt  = 1'b1;
          end
        end
        LOW: begin
          if (cnt == lo_last) begin
            state_nxt = HIGH;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + RATIO_WD'(1);
          end
        end
        HIGH: begin
          if (cnt == hi_last) begin
            cnt_nxt = '0;
            if (runnable) begin
              state_nxt = LOW;
              rl_nxt    = ratio;
              tick_nxt  = 1'b1;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            cnt_nxt = cnt + RATIO_WD'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      rl      <= '0;
      tick    <= 1'b0;
      div_clk <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      rl      <= rl_nxt;
      tick    <= tick_nxt;
      div_clk <= (state_nxt == HIGH);
    end
  end

  assign active = (state != IDLE);

endmodule

// File: rtl/clk_div_multi.sv
// Bank of NUM_CH independent clock dividers sharing one reference clock and
// one phase-align pulse.
//   i_ref_clk   : reference clock
//   i_rst       : asynchronous active-low reset
//   i_en        : per-channel run enable
//   i_div_ratio : per-channel ratio, channel c at [c*RATIO_WD +: RATIO_WD]
//   i_sync      : phase-align pulse to all channels
//   o_div_clk   : per-channel divided clock
//   o_tick      : per-channel period-start strobe
//   o_active    : per-channel running flag
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned RATIO_WD = 8
) (
  input  logic                         i_ref_clk,
  input  logic                         i_rst,
  input  logic [NUM_CH-1:0]            i_en,
  input  logic [NUM_CH*RATIO_WD-1:0]   i_div_ratio,
  input  logic                         i_sync,
  output logic [NUM_CH-1:0]            o_div_clk,
  output logic [NUM_CH-1:0]            o_tick,
  output logic [NUM_CH-1:0]            o_active
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    clk_div_ch #(
      .RATIO_WD (RATIO_WD)
    ) u_ch (
      .clk     (i_ref_clk),
      .rst_n   (i_rst),
      .en      (i_en[c]),
      .ratio   (i_div_ratio[c*RATIO_WD +: RATIO_WD]),
      .sync    (i_sync),
      .div_clk (o_div_clk[c]),
      .tick    (o_tick[c]),
      .active  (o_active[c])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi (4 channels, 8-bit ratios).
// ch2 runs ratio 1 and ch3 ratio 0 throughout, so both must stay silent.
module tb_clk_div_multi;

  localparam int unsigned NUM_CH   = 4;
  localparam int unsigned RATIO_WD = 8;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [NUM_CH-1:0]          en;
  logic [NUM_CH*RATIO_WD-1:0] ratio;
  logic                       sync;
  logic [NUM_CH-1:0]          div_clk, tick, active;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  clk_div_multi #(
    .NUM_CH   (NUM_CH),
    .RATIO_WD (RATIO_WD)
  ) dut (
    .i_ref_clk   (clk),
    .i_rst       (rst),
    .i_en        (en),
    .i_div_ratio (ratio),
    .i_sync      (sync),
    .o_div_clk   (div_clk),
    .o_tick      (tick),
    .o_active    (active)
  );

  task automatic check(input string tag, input int k,
                       input logic [NUM_CH-1:0] got, input logic [NUM_CH-1:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s @k=%0d: observed %b expected %b", tag, k, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs of one channel whose current period train began at
  // cycle 'base' with ratio r (r == 0 means the channel is idle).
  task automatic chan(input int k, input int base, input int r,
                      output logic d, output logic t, output logic a);
    int p;
    if (r == 0 || k < base) begin
      d = 1'b0; t = 1'b0; a = 1'b0;
    end else begin
      p = (k - base) % r;
      d = (p >= r / 2);
      t = (p == 0);
      a = 1'b1;
    end
  endtask

  task automatic check_all(input string tag, input int k,
                           input int b0, input int r0, input int b1, input int r1);
    logic [NUM_CH-1:0] ed, et, ea;
    logic d, t, a;
    ed = '0; et = '0; ea = '0;
    chan(k, b0, r0, d, t, a);
    ed[0] = d; et[0] = t; ea[0] = a;
    chan(k, b1, r1, d, t, a);
    ed[1] = d; et[1] = t; ea[1] = a;
    check({tag, ".div"},    k, div_clk, ed);
    check({tag, ".tick"},   k, tick,    et);
    check({tag, ".active"}, k, active,  ea);
  endtask

  initial begin
    int b0, r0, b1, r1;

    rst   = 1'b1;
    en    = 4'b1111;
    ratio = {8'd0, 8'd1, 8'd5, 8'd4};
    sync  = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("rst_async.div", 0, div_clk, '0);
    check("rst_async.tick", 0, tick, '0);
    check("rst_async.active", 0, active, '0);
    step();
    step();
    check("rst_held.div", 0, div_clk, '0);
    check("rst_held.tick", 0, tick, '0);
    check("rst_held.active", 0, active, '0);
    #2 rst = 1'b1;

    // k counts rising edges after reset release.
    for (int k = 1; k <= 75; k++) begin
      step();
      // ch0: ratio 4 from k=1, ratio 6 from boundary k=21, stopped at k=45,
      // restarted ratio 3 at k=53, resynced at k=61.
      if (k < 21)      begin b0 = 1;  r0 = 4; end
      else if (k < 45) begin b0 = 21; r0 = 6; end
      else if (k < 53) begin b0 = 0;  r0 = 0; end
      else if (k < 61) begin b0 = 53; r0 = 3; end
      else             begin b0 = 61; r0 = 3; end
      // ch1: ratio 5 from k=1, ratio 6 from boundary k=51, resynced at k=61.
      if (k < 51)      begin b1 = 1;  r1 = 5; end
      else if (k < 61) begin b1 = 51; r1 = 6; end
      else             begin b1 = 61; r1 = 6; end
      check_all("run", k, b0, r0, b1, r1);

      if (k == 18) ratio[7:0]  = 8'd6;       // one cycle after ch0 tick at 17
      if (k == 42) en[0]       = 1'b0;       // ch0 in first HIGH cycle
      if (k == 50) begin
        ratio[7:0]  = 8'd3;
        ratio[15:8] = 8'd6;
      end
      if (k == 52) en[0] = 1'b1;
      if (k == 60) sync  = 1'b1;
      if (k == 61) sync  = 1'b0;
    end

    // ch0 is mid-HIGH (ratio 3, phase 2) here; reset between clock edges.
    ratio[7:0] = 8'd4;
    #2 rst = 1'b0;
    #1;
    check("rst_mid.div", 76, div_clk, '0);
    check("rst_mid.tick", 76, tick, '0);
    check("rst_mid.active", 76, active, '0);
    step();
    check("rst_mid_held.active", 76, active, '0);
    #3 rst = 1'b1;

    for (int j = 1; j <= 12; j++) begin
      step();
      check_all("post_rst", j, 1, 4, 1, 6);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
